// File: rtl/light_pkg.sv
// Shared types and constants for the lane-select to lamp sequencing path.
// Lane bit order matches the DayTime output word: N1 N2 E1 E2 S1 S2 W1 W2 (MSB first).
package light_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    ALL_RED = 2'd3
  } phase_t;

  localparam int NUM_LANES = 8;

  localparam int N1 = 7;
  localparam int N2 = 6;
  localparam int E1 = 5;
  localparam int E2 = 4;
  localparam int S1 = 3;
  localparam int S2 = 2;
  localparam int W1 = 1;
  localparam int W2 = 0;

  localparam logic [NUM_LANES-1:0] ALL_RED_MASK = 8'hFF;

  // A lamp set is safe when every lane shows exactly one aspect.
  function automatic logic lampsOneHot(input logic [NUM_LANES-1:0] g,
                                       input logic [NUM_LANES-1:0] y,
                                       input logic [NUM_LANES-1:0] r);
    lampsOneHot = ((g | y | r) == ALL_RED_MASK) && ((g & y) == '0) &&
                  ((g & r) == '0) && ((y & r) == '0);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase durations; holds at zero until reloaded.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             zero
);

  logic [CNT_W-1:0] countR;

  // Count down; a load on the same edge as zero keeps the timer from wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countR <= '0;
    end else if (load) begin
      countR <= loadVal;
    end else if (countR != '0) begin
      countR <= countR - CNT_W'(1);
    end else begin
      countR <= countR;
    end
  end

  assign zero = (countR == '0);

endmodule

// File: rtl/light_phase_sequencer.sv
// Turns a DayTime lane-select word into a timed green / yellow / all-red phase
// with bounded green extension while the same lanes stay selected.
module light_phase_sequencer #(
  parameter int NUM_LANES     = light_pkg::NUM_LANES,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int MAX_EXT       = 2,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] lane_req,
  output logic [NUM_LANES-1:0] green,
  output logic [NUM_LANES-1:0] yellow,
  output logic [NUM_LANES-1:0] red,
  output logic                 busy,
  output logic                 phase_done
);

  import light_pkg::*;

  localparam int EXT_W = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [NUM_LANES-1:0] ALL_ON  = {NUM_LANES{1'b1}};

  phase_t               stateR;
  logic [NUM_LANES-1:0] activeR;
  logic [EXT_W-1:0]     extCntR;
  logic                 phaseDoneR;

  logic                 timerLoad;
  logic [CNT_W-1:0]     timerLoadVal;
  logic                 timerZero;
  logic                 extendOk;

  phase_timer #(
    .CNT_W(CNT_W)
  ) uTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timerLoad),
    .loadVal (timerLoadVal),
    .zero    (timerZero)
  );

  // Extension only when the same lane set is still requested and budget remains.
  always_comb begin
    extendOk = (lane_req == activeR) && (extCntR < EXT_W'(MAX_EXT));
  end

  // Timer reload selection at each phase boundary.
  always_comb begin
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    case (stateR)
      IDLE: begin
        if (lane_req != '0) begin
          timerLoad    = 1'b1;
          timerLoadVal = GREEN_LOAD;
        end else begin
          timerLoad    = 1'b0;
        end
      end
      GREEN: begin
        if (timerZero) begin
          timerLoad    = 1'b1;
          timerLoadVal = extendOk ? GREEN_LOAD : YELLOW_LOAD;
        end else begin
          timerLoad    = 1'b0;
        end
      end
      YELLOW: begin
        if (timerZero) begin
          timerLoad    = 1'b1;
          timerLoadVal = ALLRED_LOAD;
        end else begin
          timerLoad    = 1'b0;
        end
      end
      ALL_RED: timerLoad = 1'b0;
      default: timerLoad = 1'b0;
    endcase
  end

  // Phase FSM; lane_req is only sampled in IDLE and at green expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR     <= IDLE;
      activeR    <= '0;
      extCntR    <= '0;
      phaseDoneR <= 1'b0;
    end else begin
      phaseDoneR <= 1'b0;
      case (stateR)
        IDLE: begin
          if (lane_req != '0) begin
            activeR <= lane_req;
            extCntR <= '0;
            stateR  <= GREEN;
          end
        end
        GREEN: begin
          if (timerZero) begin
            if (extendOk) begin
              extCntR <= extCntR + EXT_W'(1);
            end else begin
              stateR <= YELLOW;
            end
          end
        end
        YELLOW: begin
          if (timerZero) begin
            stateR <= ALL_RED;
          end
        end
        ALL_RED: begin
          if (timerZero) begin
            stateR     <= IDLE;
            activeR    <= '0;
            phaseDoneR <= 1'b1;
          end
        end
        default: begin
          stateR  <= IDLE;
          activeR <= '0;
          extCntR <= '0;
        end
      endcase
    end
  end

  // Lamp decode from registered state only; anything unexpected shows all red.
  always_comb begin
    green  = '0;
    yellow = '0;
    red    = ALL_ON;
    case (stateR)
      GREEN: begin
        green = activeR;
        red   = ~activeR;
      end
      YELLOW: begin
        yellow = activeR;
        red    = ~activeR;
      end
      IDLE:    red = ALL_ON;
      ALL_RED: red = ALL_ON;
      default: red = ALL_ON;
    endcase
  end

  assign busy       = (stateR != IDLE);
  assign phase_done = phaseDoneR;

endmodule
